// File: rtl/iot_pkg.sv
// Shared constants, state encoding and helpers for the IoT byte-serial transmitter.
// The optional word FIFO is selected with the IOT_TX_FIFO_EN macro in iot_byte_tx.
package iot_pkg;

  localparam int IOT_BYTES_PER_WORD      = 16;
  localparam int IOT_WORD_W              = 128;
  localparam int IOT_WORDS_PER_ROUND_DEF = 8;
  localparam int IOT_FIFO_DEPTH_DEF      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } iot_state_e;

  typedef logic [IOT_WORD_W-1:0] iot_word_t;

  // Byte lane idx of a word, lane 0 being the least-significant byte.
  function automatic logic [7:0] iot_byte_sel(input iot_word_t w, input logic [3:0] idx);
    return w[8*idx +: 8];
  endfunction

endpackage

// File: rtl/iot_byte_tx_if.sv
// Upstream sample handshake plus downstream byte port of the IoT transmitter.
// The transmitter uses the slave view; the sample source / filter side uses master.
interface iot_byte_tx_if;
  import iot_pkg::*;

  logic       s_valid;
  iot_word_t  s_data;
  logic       s_ready;
  logic       busy;
  logic       in_en;
  logic [7:0] iot_in;
  logic [2:0] word_cnt;
  logic       round_done;

  modport slave (
    input  s_valid, s_data, busy,
    output s_ready, in_en, iot_in, word_cnt, round_done
  );

  modport master (
    output s_valid, s_data, busy,
    input  s_ready, in_en, iot_in, word_cnt, round_done
  );

endinterface

// File: rtl/iot_tx_fifo.sv
// Show-ahead word FIFO with a registered head word and full/empty flags.
// Storage is a plain array so it maps onto block RAM; the head register bypasses it when empty.
module iot_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rd_next;
  logic [AW:0]      w_cnt_after_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_head;

  // A push into a full FIFO is legal only when a pop frees a slot on the same edge.
  assign w_push          = i_push && (!o_full || i_pop);
  assign w_pop           = i_pop && !o_empty;
  assign w_rd_next       = r_rd_ptr + AW'(w_pop);
  assign w_cnt_after_pop = r_count - (AW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_cnt_after_pop + (AW+1)'(w_push);
    end
  end

  // Incoming word becomes the head directly when nothing else will be left in the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
    end else if (w_push && (w_cnt_after_pop == '0)) begin
      r_head <= i_data;
    end else begin
      r_head <= r_mem[w_rd_next];
    end
  end

endmodule

// File: rtl/iot_byte_tx.sv
// Serializes 128-bit samples into 16 LSB-first bytes with busy stall and a one-cycle word gap.
// Define IOT_TX_FIFO_EN to hold samples in an iot_tx_fifo instead of a single register.
module iot_byte_tx
  import iot_pkg::*;
#(
  parameter int WORDS_PER_ROUND = IOT_WORDS_PER_ROUND_DEF,
  parameter int FIFO_DEPTH      = IOT_FIFO_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  iot_byte_tx_if.slave tx
);

  localparam logic [3:0] LAST_BYTE = 4'(IOT_BYTES_PER_WORD - 1);
  localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_ROUND - 1);

  generate
    if (WORDS_PER_ROUND < 1 || WORDS_PER_ROUND > 8) begin : g_bad_round
      $error("iot_byte_tx: WORDS_PER_ROUND must be in 1..8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("iot_byte_tx: FIFO_DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  iot_state_e r_state;
  iot_state_e w_state_next;
  logic [3:0] r_byte_idx;
  logic [2:0] r_word_cnt;
  logic       r_round_done;

  logic       w_in_en;
  logic [7:0] w_iot_in;
  logic       w_push;
  logic       w_pop;
  logic       w_s_ready;
  logic       w_store_nonempty;
  iot_word_t  w_head;

  assign w_push = tx.s_valid && w_s_ready;
  assign w_pop  = w_in_en && (r_byte_idx == LAST_BYTE);

`ifdef IOT_TX_FIFO_EN
  logic w_fifo_full;
  logic w_fifo_empty;

  iot_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IOT_WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (tx.s_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_s_ready        = !w_fifo_full || w_pop;
  assign w_store_nonempty = !w_fifo_empty;
`else
  iot_word_t r_word;
  logic      r_full;

  // Push and pop never coincide here: s_ready is low for the whole word being sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_pop) begin
        r_full <= 1'b0;
      end
      if (w_push) begin
        r_word <= tx.s_data;
        r_full <= 1'b1;
      end
    end
  end

  assign w_s_ready        = !r_full;
  assign w_store_nonempty = r_full;
  assign w_head           = r_word;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A sample accepted this edge starts sending next cycle, so push counts as non-empty.
  always_comb begin
    w_state_next = r_state;
    w_in_en      = 1'b0;
    w_iot_in     = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (w_push || w_store_nonempty) begin
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        w_in_en  = !tx.busy;
        w_iot_in = iot_byte_sel(w_head, r_byte_idx);
        if (w_in_en && (r_byte_idx == LAST_BYTE)) begin
          w_state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        w_state_next = (w_push || w_store_nonempty) ? ST_SEND : ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_idx   <= '0;
      r_word_cnt   <= '0;
      r_round_done <= 1'b0;
    end else begin
      r_round_done <= 1'b0;
      if (w_in_en) begin
        r_byte_idx <= r_byte_idx + 4'd1;
      end
      if (w_pop) begin
        r_word_cnt   <= (r_word_cnt == LAST_WORD) ? 3'd0 : r_word_cnt + 3'd1;
        r_round_done <= (r_word_cnt == LAST_WORD);
      end
    end
  end

  assign tx.s_ready    = w_s_ready;
  assign tx.in_en      = w_in_en;
  assign tx.iot_in     = w_iot_in;
  assign tx.word_cnt   = r_word_cnt;
  assign tx.round_done = r_round_done;

endmodule

// File: tb/tb_iot_byte_tx.sv
// Bench for iot_byte_tx: vector table, directed corner sequences and random traffic
// checked every cycle against a byte-queue model of the transmitter.
module tb_iot_byte_tx;
  import iot_pkg::*;

  localparam int WPR   = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iot_byte_tx_if bus();

  iot_byte_tx #(
    .WORDS_PER_ROUND (WPR),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tx  (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: pending bytes of accepted samples, a gap after every 16th byte, busy stalls.
  logic [7:0] m_q[$];
  int         m_bytes = 0;
  int         m_words = 0;
  bit         m_gap = 0;
  bit         m_rd = 0;
  bit         m_pushed = 0;
  int         cyc_n = 0;
  int         start_q[$];
  int         rd_pulses = 0;

  always @(negedge clk) begin
    bit         e_en;
    bit         e_ready;
    logic [7:0] e_byte;
    int         pw;
    cyc_n++;
    if (rst) begin
      chk("rst_in_en", bus.in_en, 0);
      chk("rst_iot_in", bus.iot_in, 0);
      chk("rst_s_ready", bus.s_ready, 1);
      chk("rst_word_cnt", bus.word_cnt, 0);
      chk("rst_round_done", bus.round_done, 0);
      m_q.delete();
      m_bytes  = 0;
      m_words  = 0;
      m_gap    = 0;
      m_rd     = 0;
      m_pushed = 0;
    end else begin
      e_en   = !bus.busy && (m_q.size() > 0) && !m_gap;
      e_byte = ((m_q.size() > 0) && !m_gap) ? m_q[0] : 8'h00;
      pw     = (m_q.size() + 15) / 16;
`ifdef IOT_TX_FIFO_EN
      e_ready = (pw < DEPTH) || (e_en && (m_q.size() % 16 == 1));
`else
      e_ready = (pw == 0);
`endif
      chk("in_en", bus.in_en, e_en);
      chk("iot_in", bus.iot_in, e_byte);
      chk("s_ready", bus.s_ready, e_ready);
      chk("word_cnt", bus.word_cnt, m_words % WPR);
      chk("round_done", bus.round_done, m_rd);
      if (bus.round_done) rd_pulses++;
      m_gap = 0;
      m_rd  = 0;
      if (e_en) begin
        if (m_bytes % 16 == 0) start_q.push_back(cyc_n);
        void'(m_q.pop_front());
        m_bytes++;
        if (m_bytes % 16 == 0) begin
          m_gap = 1;
          m_words++;
          m_rd = (m_words % WPR == 0);
        end
      end
      m_pushed = bus.s_valid && e_ready;
      if (m_pushed) begin
        for (int i = 0; i < 16; i++) m_q.push_back(bus.s_data[8*i +: 8]);
      end
    end
  end

  function automatic logic [127:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic reset_dut();
    @(posedge clk); #1;
    bus.s_valid = 0;
    bus.busy    = 0;
    rst         = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic feed(input int n, input int busy_pct, input bit rand_valid, input int max_c);
    int sent = 0;
    int c = 0;
    @(posedge clk); #1;
    bus.s_valid = 1;
    bus.s_data  = rnd_word();
    bus.busy    = 0;
    while ((sent < n || m_q.size() > 0) && c < max_c) begin
      @(posedge clk); #1;
      c++;
      if (m_pushed) begin
        sent++;
        bus.s_data = rnd_word();
      end
      bus.s_valid = (sent < n) && (!rand_valid || $urandom_range(0, 3) != 0);
      bus.busy    = ($urandom_range(0, 99) < busy_pct);
    end
    bus.s_valid = 0;
    bus.busy    = 0;
    chk("feed_in_time", (c < max_c), 1);
  endtask

  typedef struct {
    bit         push;
    bit         busy;
    bit         exp_en;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t        tbl[$];
  logic [127:0] pat;
  logic [127:0] w2;

  initial begin
    int c;
    pat = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
    w2  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5A5A_C3A7;
    bus.s_valid = 0;
    bus.s_data  = '0;
    bus.busy    = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Word 1 plain, word 2 with busy held for 3 cycles while byte 5 is presented.
    tbl.push_back('{1, 0, 0, 8'h00});
    for (int i = 0; i < 16; i++) tbl.push_back('{0, 0, 1, 8'(i)});
    tbl.push_back('{1, 0, 0, 8'h00});
    for (int i = 0; i < 5; i++) tbl.push_back('{0, 0, 1, 8'(i)});
    repeat (3) tbl.push_back('{0, 1, 0, 8'h05});
    for (int i = 5; i < 16; i++) tbl.push_back('{0, 0, 1, 8'(i)});
    tbl.push_back('{0, 0, 0, 8'h00});
    tbl.push_back('{0, 0, 0, 8'h00});
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      bus.s_valid = tbl[i].push;
      bus.s_data  = pat;
      bus.busy    = tbl[i].busy;
      @(negedge clk);
      chk("tbl_in_en", bus.in_en, tbl[i].exp_en);
      chk("tbl_iot_in", bus.iot_in, tbl[i].exp_byte);
    end
    chk("tbl_word_cnt", bus.word_cnt, 2);

    // Eight back-to-back words: one round_done pulse, counter wraps to 0, 17-cycle spacing.
    reset_dut();
    rd_pulses = 0;
    start_q.delete();
    feed(8, 0, 0, 400);
    repeat (3) @(negedge clk);
    chk("round_done_pulses", rd_pulses, 1);
    chk("wc_after_wrap", bus.word_cnt, 0);
    chk("round_word_starts", start_q.size(), 8);
    for (int i = 1; i < start_q.size(); i++)
      chk("word_spacing", start_q[i] - start_q[i-1], 17);

`ifdef IOT_TX_FIFO_EN
    // Burst of four samples on consecutive cycles into the FIFO.
    reset_dut();
    start_q.delete();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      bus.s_valid = 1;
      bus.s_data  = rnd_word();
      @(negedge clk);
      chk("burst_ready", bus.s_ready, 1);
    end
    @(posedge clk); #1;
    bus.s_valid = 0;
    @(negedge clk);
    chk("burst_full_ready", bus.s_ready, 0);
    c = 0;
    while (m_q.size() > 0 && c < 200) begin
      @(posedge clk);
      c++;
    end
    chk("burst_drained", (c < 200), 1);
    chk("burst_word_starts", start_q.size(), 4);
    for (int i = 1; i < start_q.size(); i++)
      chk("burst_spacing", start_q[i] - start_q[i-1], 17);
`endif

    // Reset while byte 9 of word 2 is on the port.
    reset_dut();
    bus.s_valid = 1;
    bus.s_data  = rnd_word();
    c = 0;
    while (m_bytes != 41 && c < 300) begin
      @(posedge clk); #1;
      c++;
      if (m_pushed) bus.s_data = rnd_word();
    end
    chk("reach_w2_b9", (c < 300), 1);
    chk("pre_rst_in_en", bus.in_en, 1);
    rst = 1;
    bus.s_valid = 0;
    #1;
    chk("midrst_in_en", bus.in_en, 0);
    chk("midrst_iot_in", bus.iot_in, 0);
    chk("midrst_word_cnt", bus.word_cnt, 0);
    chk("midrst_s_ready", bus.s_ready, 1);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    bus.s_valid = 1;
    bus.s_data  = w2;
    @(posedge clk); #1;
    bus.s_valid = 0;
    @(negedge clk);
    chk("post_rst_in_en", bus.in_en, 1);
    chk("post_rst_byte0", bus.iot_in, w2[7:0]);
    chk("post_rst_word_cnt", bus.word_cnt, 0);
    repeat (20) @(posedge clk);

    // Random traffic with random valid gaps and busy stalls.
    reset_dut();
    feed(40, 25, 1, 5000);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
